reg_bank_snap: RTL and testbench
================================

// Module: reg_bank_snap
// PURPOSE
//  Parametrised multi-entry D-register bank. It is the clocked, addressable generalisation of the single-bit D storage cell.
//  Provides one synchronous write port and two asynchronous read ports.
//  Adds a freeze mode that blocks writes while reads continue, a saturating counter of dropped writes, and per-entry dirty tracking.
//  Used as general-purpose state storage, e.g. a CPU register file or a debug snapshot bank.
// PARAMETERS
//  WIDTH     32  data bits per entry (>=1)
//  DEPTH     8   number of entries; power of two, >=2
//  ZERO_REG  1   1: entry 0 is hard-wired to 0 and ignores writes; 0: entry 0 is a normal entry
//  CNTW      8   width of the dropped-write counter (>=1)
//  AW        $clog2(DEPTH), derived localparam; not overridable
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      asynchronous reset, active-high
//  we        in   1      write enable
//  waddr     in   AW     write address
//  wdata     in   WIDTH  write data
//  raddr_a   in   AW     read address, port A
//  raddr_b   in   AW     read address, port B
//  qa        out  WIDTH  read data, port A (combinational)
//  qb        out  WIDTH  read data, port B (combinational)
//  freeze    in   1      1: writes blocked, reads unaffected
//  clear     in   1      synchronous clear of all state
//  dirty     out  DEPTH  bit i = 1: entry i written since the last reset or clear
//  drop_cnt  out  CNTW   count of writes blocked by freeze; saturates
// BEHAVIOUR
//  Reset (rst=1, asynchronous, no clock needed):
//   - all entries = 0, dirty = 0, drop_cnt = 0
//   - hence qa = qb = 0 throughout reset
//  Reads:
//   - qa = mem[raddr_a], qb = mem[raddr_b]; zero-cycle latency, no write bypass
//   - reading the address being written in the same cycle returns the OLD value; the new value appears after the edge
//   - ZERO_REG=1: a read of address 0 always returns 0
//  Write, at posedge clk, with clear=0:
//   - if we & ~freeze & ~(ZERO_REG & waddr==0): mem[waddr] <= wdata and dirty[waddr] <= 1
//   - ZERO_REG=1 with waddr==0: no effect at all (no dirty bit, no drop count)
//   - if we & freeze: mem and dirty unchanged; drop_cnt <= drop_cnt+1, held at 2^CNTW-1 (no wrap)
//   - the ZERO_REG address-0 rule takes precedence over freeze: a frozen write to address 0 is not counted
//  Clear, at posedge clk with clear=1:
//   - all entries, dirty and drop_cnt <= 0
//   - clear overrides a write and any drop count in the same cycle
//   - clear works while freeze=1
//  Freeze:
//   - level-sensitive, sampled at each edge; no state machine
//   - deasserting freeze allows writes at the very next edge
//  Width/arithmetic rules:
//   - drop_cnt is unsigned
//   - waddr, raddr_a and raddr_b cover the full DEPTH; there are no out-of-range addresses
//  Reset mid-operation: an asynchronous rst asserted between edges zeroes all state immediately; a pending write is lost
// TESTING
//  T1 reset: rst=1 mid-cycle after writes -> qa=qb=0, dirty=0, drop_cnt=0 before the next edge
//  T2 write/read: we=1, waddr=3, wdata=32'hDEADBEEF, raddr_a=3
//     -> qa=old value in the write cycle, 32'hDEADBEEF after the edge; dirty=8'b0000_1000
//  T3 zero reg: ZERO_REG=1, write 32'h1234 to address 0 -> qa(raddr_a=0)=0, dirty[0]=0, drop_cnt unchanged
//  T4 freeze: freeze=1 with 300 write cycles to address 5, CNTW=8 -> mem[5] unchanged, drop_cnt=255 (saturated);
//     freeze=0 then one write -> mem[5] updated after the next edge
//  T5 clear vs write: clear=1 and we=1 (waddr=2) in the same cycle -> all entries 0, dirty=0, drop_cnt=0
//  T6 dual read: raddr_a=2, raddr_b=7 after distinct writes -> qa and qb independently correct in the same cycle

Source files
------------

// File: rtl/reg_bank_snap.sv
// Multi-entry D-register bank: one synchronous write port, two async read ports,
// freeze mode with saturating dropped-write counter and per-entry dirty bits.
module reg_bank_snap #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int ZERO_REG = 1,
    parameter int CNTW     = 8,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] qa,
    output logic [WIDTH-1:0] qb,
    input  logic             freeze,
    input  logic             clear,
    output logic [DEPTH-1:0] dirty,
    output logic [CNTW-1:0]  drop_cnt
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_dirty;
    logic [CNTW-1:0]  r_drop;

    logic w_zero_hit;
    logic w_wr;
    logic w_drop;
    logic w_sat;

    // Address 0 on a zero-register bank swallows the write before freeze is considered
    assign w_zero_hit = (ZERO_REG != 0) && (waddr == '0);
    assign w_wr       = we && !freeze && !w_zero_hit;
    assign w_drop     = we && freeze && !w_zero_hit;
    assign w_sat      = &r_drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_dirty <= '0;
            r_drop  <= '0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_dirty <= '0;
            r_drop  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[waddr]   <= wdata;
                r_dirty[waddr] <= 1'b1;
            end
            if (w_drop && !w_sat) begin
                r_drop <= r_drop + CNTW'(1);
            end
        end
    end

    always_comb begin
        qa = r_mem[raddr_a];
        qb = r_mem[raddr_b];
        if ((ZERO_REG != 0) && (raddr_a == '0)) begin
            qa = '0;
        end
        if ((ZERO_REG != 0) && (raddr_b == '0)) begin
            qb = '0;
        end
    end

    assign dirty    = r_dirty;
    assign drop_cnt = r_drop;

endmodule

// File: tb/tb_reg_bank_snap.sv
// Directed testbench for reg_bank_snap with default parameters.
// Hand-computed expectations checked by immediate assertions.
module tb_reg_bank_snap;

    logic        clk;
    logic        rst;
    logic        we;
    logic [2:0]  waddr;
    logic [31:0] wdata;
    logic [2:0]  raddr_a;
    logic [2:0]  raddr_b;
    logic [31:0] qa;
    logic [31:0] qb;
    logic        freeze;
    logic        clear;
    logic [7:0]  dirty;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

    reg_bank_snap dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr_a  (raddr_a),
        .raddr_b  (raddr_b),
        .qa       (qa),
        .qb       (qb),
        .freeze   (freeze),
        .clear    (clear),
        .dirty    (dirty),
        .drop_cnt (drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b0;
        we      = 1'b0;
        waddr   = '0;
        wdata   = '0;
        raddr_a = '0;
        raddr_b = '0;
        freeze  = 1'b0;
        clear   = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_qa", qa, 32'h0);
        chk("rst_qb", qb, 32'h0);
        chk("rst_dirty", {24'h0, dirty}, 32'h0);
        chk("rst_drop", {24'h0, drop_cnt}, 32'h0);
        rst = 1'b0;
        tick();

        // T2 write/read with old-value-before-edge
        we = 1'b1; waddr = 3'd3; wdata = 32'hDEADBEEF; raddr_a = 3'd3;
        #1;
        chk("t2_old", qa, 32'h0);
        tick();
        chk("t2_new", qa, 32'hDEADBEEF);
        chk("t2_dirty", {24'h0, dirty}, 32'h08);

        // T3 zero register
        waddr = 3'd0; wdata = 32'h1234; raddr_a = 3'd0;
        tick();
        chk("t3_qa", qa, 32'h0);
        chk("t3_dirty", {24'h0, dirty}, 32'h08);
        chk("t3_drop", {24'h0, drop_cnt}, 32'h0);

        // T6 dual read
        waddr = 3'd2; wdata = 32'h22222222;
        tick();
        waddr = 3'd7; wdata = 32'h77770007;
        tick();
        we = 1'b0; raddr_a = 3'd2; raddr_b = 3'd7;
        #1;
        chk("t6_qa", qa, 32'h22222222);
        chk("t6_qb", qb, 32'h77770007);
        chk("t6_dirty", {24'h0, dirty}, 32'h8C);

        // T4 freeze and saturation
        we = 1'b1; waddr = 3'd5; wdata = 32'h55;
        tick();
        freeze = 1'b1; wdata = 32'hAAAA; raddr_a = 3'd5;
        tick();
        chk("t4_drop1", {24'h0, drop_cnt}, 32'd1);
        chk("t4_hold", qa, 32'h55);
        waddr = 3'd0;
        tick();
        chk("t4_zero_nocnt", {24'h0, drop_cnt}, 32'd1);
        waddr = 3'd5;
        for (int i = 0; i < 253; i++) begin
            wdata = 32'h1000 + i;
            tick();
        end
        chk("t4_drop254", {24'h0, drop_cnt}, 32'd254);
        for (int i = 0; i < 46; i++) begin
            wdata = 32'h2000 + i;
            tick();
        end
        chk("t4_sat", {24'h0, drop_cnt}, 32'd255);
        chk("t4_mem5", qa, 32'h55);
        chk("t4_dirty", {24'h0, dirty}, 32'hAC);
        freeze = 1'b0; wdata = 32'h5A5A;
        #1;
        chk("t4_pre", qa, 32'h55);
        tick();
        chk("t4_post", qa, 32'h5A5A);
        chk("t4_drop_kept", {24'h0, drop_cnt}, 32'd255);

        // T5 clear beats a same-cycle write
        clear = 1'b1; waddr = 3'd2; wdata = 32'hFFFF;
        tick();
        clear = 1'b0; we = 1'b0;
        #1;
        chk("t5_qa", qa, 32'h0);
        chk("t5_qb", qb, 32'h0);
        chk("t5_dirty", {24'h0, dirty}, 32'h0);
        chk("t5_drop", {24'h0, drop_cnt}, 32'h0);
        raddr_a = 3'd2;
        #1;
        chk("t5_mem2", qa, 32'h0);

        // Clear while frozen
        we = 1'b1; waddr = 3'd4; wdata = 32'h44; raddr_a = 3'd4;
        tick();
        freeze = 1'b1;
        tick();
        chk("fz_drop", {24'h0, drop_cnt}, 32'd1);
        chk("fz_dirty", {24'h0, dirty}, 32'h10);
        we = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0; freeze = 1'b0;
        chk("fzclr_qa", qa, 32'h0);
        chk("fzclr_dirty", {24'h0, dirty}, 32'h0);
        chk("fzclr_drop", {24'h0, drop_cnt}, 32'h0);

        // T1 asynchronous reset mid-cycle, pending write lost
        we = 1'b1; waddr = 3'd6; wdata = 32'h66; raddr_a = 3'd6;
        tick();
        freeze = 1'b1;
        tick();
        chk("t1_pre_qa", qa, 32'h66);
        chk("t1_pre_drop", {24'h0, drop_cnt}, 32'd1);
        freeze = 1'b0; waddr = 3'd1; wdata = 32'h11; raddr_b = 3'd1;
        #1 rst = 1'b1;
        #1;
        chk("t1_qa", qa, 32'h0);
        chk("t1_dirty", {24'h0, dirty}, 32'h0);
        chk("t1_drop", {24'h0, drop_cnt}, 32'h0);
        tick();
        we = 1'b0; rst = 1'b0;
        tick();
        chk("t1_lost", qb, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
